// File: rtl/atomrvcore_boot_ctrl.sv
// Boot/load sequencer: streams a program image into ICCM, then releases the core reset.
// Optional CHECKSUM_EN adds a trailing checksum beat that must make the word sum zero.
module atomrvcore_boot_ctrl #(
    parameter int DATAWIDTH  = 32,
    parameter int ICCM_DEPTH = 1024,
    parameter int START_ADDR = 0,
    parameter int RST_HOLD   = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [$clog2(ICCM_DEPTH):0]     len_i,
    input  logic [DATAWIDTH-1:0]            data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic                            IWR_EN_o,
    output logic                            IR_EN_o,
    output logic [DATAWIDTH-1:0]            address_o,
    output logic [DATAWIDTH-1:0]            DATA_o,
    output logic                            core_rst_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
);
    localparam int LW = $clog2(ICCM_DEPTH) + 1;
    localparam int HW = $clog2(RST_HOLD) + 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    logic [2:0]           state;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        cnt;
    logic [HW-1:0]        hold_cnt;
    logic [DATAWIDTH-1:0] addr;
`ifdef CHECKSUM_EN
    logic [DATAWIDTH-1:0] sum;
`endif

    logic len_ok;
    assign len_ok  = (len_i != '0) && (len_i <= LW'(ICCM_DEPTH));
    assign ready_o = (state == ST_LOAD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            cnt        <= '0;
            hold_cnt   <= '0;
            addr       <= DATAWIDTH'(START_ADDR);
            IWR_EN_o   <= 1'b0;
            IR_EN_o    <= 1'b0;
            address_o  <= DATAWIDTH'(START_ADDR);
            DATA_o     <= '0;
            core_rst_o <= 1'b1;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
`ifdef CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            IWR_EN_o <= 1'b0;
            case (state)
                // RUN shares IDLE's start handling: a valid start restarts the load
                ST_IDLE, ST_RUN: begin
                    if (start_i) begin
                        core_rst_o <= 1'b1;
                        IR_EN_o    <= 1'b0;
                        done_o     <= 1'b0;
                        if (len_ok) begin
                            state  <= ST_LOAD;
                            len_q  <= len_i;
                            cnt    <= '0;
                            addr   <= DATAWIDTH'(START_ADDR);
                            busy_o <= 1'b1;
`ifdef CHECKSUM_EN
                            sum    <= '0;
`endif
                        end else begin
                            state  <= ST_ERR;
                            err_o  <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (valid_i) begin
`ifdef CHECKSUM_EN
                        if (cnt == len_q) begin
                            // checksum beat: never written to ICCM
                            if ((sum + data_i) == '0) begin
                                state    <= ST_HOLD;
                                hold_cnt <= '0;
                            end else begin
                                state  <= ST_ERR;
                                err_o  <= 1'b1;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            IWR_EN_o  <= 1'b1;
                            DATA_o    <= data_i;
                            address_o <= addr;
                            addr      <= addr + DATAWIDTH'(4);
                            cnt       <= cnt + LW'(1);
                            sum       <= sum + data_i;
                        end
`else
                        IWR_EN_o  <= 1'b1;
                        DATA_o    <= data_i;
                        address_o <= addr;
                        addr      <= addr + DATAWIDTH'(4);
                        cnt       <= cnt + LW'(1);
                        if (cnt == len_q - LW'(1)) begin
                            state    <= ST_HOLD;
                            hold_cnt <= '0;
                        end
`endif
                    end
                end
                // first HOLD cycle is counted as hold cycle 0
                ST_HOLD: begin
                    if (hold_cnt == HW'(RST_HOLD - 1)) begin
                        state      <= ST_RUN;
                        core_rst_o <= 1'b0;
                        IR_EN_o    <= 1'b1;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_ERR: begin
                    core_rst_o <= 1'b1;
                    IR_EN_o    <= 1'b0;
                end
                default: state <= ST_ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_atomrvcore_boot_ctrl.sv
// Directed bench for atomrvcore_boot_ctrl; the checksum case runs only when CHECKSUM_EN is defined.
module tb_atomrvcore_boot_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [10:0] len_i = '0;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o, IWR_EN_o, IR_EN_o, core_rst_o, busy_o, done_o, err_o;
    logic [31:0] address_o, DATA_o;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;
    int excl_viol = 0;
    int wr0;

    atomrvcore_boot_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .IWR_EN_o(IWR_EN_o), .IR_EN_o(IR_EN_o), .address_o(address_o),
        .DATA_o(DATA_o), .core_rst_o(core_rst_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (IWR_EN_o) wr_cnt++;
        if (IWR_EN_o && IR_EN_o) excl_viol++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0; valid_i = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},  {31'b0, ready_o},    32'd0);
        chk({tag, "_iwr"},  {31'b0, IWR_EN_o},   32'd0);
        chk({tag, "_ir"},   {31'b0, IR_EN_o},    32'd0);
        chk({tag, "_addr"}, address_o,           32'd0);
        chk({tag, "_data"}, DATA_o,              32'd0);
        chk({tag, "_crst"}, {31'b0, core_rst_o}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy_o},     32'd0);
        chk({tag, "_done"}, {31'b0, done_o},     32'd0);
        chk({tag, "_err"},  {31'b0, err_o},      32'd0);
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic [31:0] a);
        valid_i = 1'b1; data_i = d;
        tick();
        chk({tag, "_iwr"},  {31'b0, IWR_EN_o}, 32'd1);
        chk({tag, "_addr"}, address_o, a);
        chk({tag, "_data"}, DATA_o, d);
        valid_i = 1'b0;
    endtask

    // last write pulse was just observed; core is released 4 cycles later
    task automatic hold_then_run(input string tag);
        chk({tag, "_hold_rdy"}, {31'b0, ready_o}, 32'd0);
        repeat (3) tick();
        chk({tag, "_hold_crst"}, {31'b0, core_rst_o}, 32'd1);
        chk({tag, "_hold_busy"}, {31'b0, busy_o}, 32'd1);
        tick();
        chk({tag, "_run_crst"}, {31'b0, core_rst_o}, 32'd0);
        chk({tag, "_run_done"}, {31'b0, done_o}, 32'd1);
        chk({tag, "_run_ir"},   {31'b0, IR_EN_o}, 32'd1);
        chk({tag, "_run_busy"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        // reset state
        do_reset();
        chk_reset_vals("rst");

        // 1: basic load of 3 back-to-back words
        wr0 = wr_cnt;
        start_i = 1'b1; len_i = 11'd3;
        tick();
        start_i = 1'b0;
        chk("t1_busy", {31'b0, busy_o}, 32'd1);
        chk("t1_rdy",  {31'b0, ready_o}, 32'd1);
        beat("t1_w0", 32'h00500093, 32'h0);
        valid_i = 1'b1;
        beat("t1_w1", 32'h00A00113, 32'h4);
        valid_i = 1'b1;
        beat("t1_w2", 32'h002081B3, 32'h8);
        hold_then_run("t1");
        chk("t1_wrcnt", wr_cnt - wr0, 32'd3);

        // 2: stalled source, 3 idle cycles between words
        do_reset();
        wr0 = wr_cnt;
        start_i = 1'b1; len_i = 11'd2;
        tick();
        start_i = 1'b0;
        beat("t2_w0", 32'hCAFE0001, 32'h0);
        tick();
        chk("t2_gap_iwr",  {31'b0, IWR_EN_o}, 32'd0);
        chk("t2_gap_addr", address_o, 32'h0);
        chk("t2_gap_data", DATA_o, 32'hCAFE0001);
        tick(); tick();
        chk("t2_gap_rdy", {31'b0, ready_o}, 32'd1);
        beat("t2_w1", 32'hCAFE0002, 32'h4);
        hold_then_run("t2");
        chk("t2_wrcnt", wr_cnt - wr0, 32'd2);

        // 3: bad lengths
        do_reset();
        wr0 = wr_cnt;
        start_i = 1'b1; len_i = 11'd0;
        tick();
        start_i = 1'b0;
        chk("t3a_err",  {31'b0, err_o}, 32'd1);
        chk("t3a_crst", {31'b0, core_rst_o}, 32'd1);
        valid_i = 1'b1; data_i = 32'h1234;
        start_i = 1'b1; len_i = 11'd1;
        tick(); tick();
        valid_i = 1'b0; start_i = 1'b0;
        chk("t3a_sticky", {31'b0, err_o}, 32'd1);
        chk("t3a_rdy",    {31'b0, ready_o}, 32'd0);
        chk("t3a_ir",     {31'b0, IR_EN_o}, 32'd0);
        chk("t3a_wrcnt",  wr_cnt - wr0, 32'd0);
        do_reset();
        chk("t3_clr_err", {31'b0, err_o}, 32'd0);
        start_i = 1'b1; len_i = 11'd1025;
        tick();
        start_i = 1'b0;
        chk("t3b_err",  {31'b0, err_o}, 32'd1);
        chk("t3b_crst", {31'b0, core_rst_o}, 32'd1);
        // boundary: len == ICCM_DEPTH is accepted
        do_reset();
        start_i = 1'b1; len_i = 11'd1024;
        tick();
        start_i = 1'b0;
        chk("t3c_err",  {31'b0, err_o}, 32'd0);
        chk("t3c_busy", {31'b0, busy_o}, 32'd1);

        // 4: reset mid-load
        do_reset();
        start_i = 1'b1; len_i = 11'd5;
        tick();
        start_i = 1'b0;
        beat("t4_w0", 32'h11111111, 32'h0);
        valid_i = 1'b1;
        beat("t4_w1", 32'h22222222, 32'h4);
        rst_i = 1'b1; valid_i = 1'b1; start_i = 1'b1;
        tick();
        rst_i = 1'b0; valid_i = 1'b0; start_i = 1'b0;
        chk_reset_vals("t4_rst");
        start_i = 1'b1; len_i = 11'd1;
        tick();
        start_i = 1'b0;
        beat("t4_w", 32'h33333333, 32'h0);
        hold_then_run("t4");

        // 5: reload from RUN
        wr0 = wr_cnt;
        start_i = 1'b1; len_i = 11'd1;
        tick();
        start_i = 1'b0;
        chk("t5_crst", {31'b0, core_rst_o}, 32'd1);
        chk("t5_ir",   {31'b0, IR_EN_o}, 32'd0);
        chk("t5_done", {31'b0, done_o}, 32'd0);
        beat("t5_w", 32'h44444444, 32'h0);
        hold_then_run("t5");
        chk("t5_wrcnt", wr_cnt - wr0, 32'd1);

`ifdef CHECKSUM_EN
        // 6: checksum good then bad
        do_reset();
        wr0 = wr_cnt;
        start_i = 1'b1; len_i = 11'd2;
        tick();
        start_i = 1'b0;
        beat("t6_w0", 32'h1, 32'h0);
        valid_i = 1'b1;
        beat("t6_w1", 32'h2, 32'h4);
        valid_i = 1'b1; data_i = 32'hFFFFFFFD;
        tick();
        valid_i = 1'b0;
        chk("t6_ck_iwr", {31'b0, IWR_EN_o}, 32'd0);
        hold_then_run("t6");
        chk("t6_wrcnt", wr_cnt - wr0, 32'd2);
        do_reset();
        start_i = 1'b1; len_i = 11'd2;
        tick();
        start_i = 1'b0;
        beat("t6b_w0", 32'h1, 32'h0);
        valid_i = 1'b1;
        beat("t6b_w1", 32'h2, 32'h4);
        valid_i = 1'b1; data_i = 32'hFFFFFFFC;
        tick();
        valid_i = 1'b0;
        chk("t6b_err",  {31'b0, err_o}, 32'd1);
        chk("t6b_done", {31'b0, done_o}, 32'd0);
`endif

        chk("excl_rd_wr", excl_viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
